arbitro_demux_dest: RTL and testbench
=====================================

ARBITRO_DEMUX_DEST -- requirements
Module: arbitro_demux_dest

Interface
REQ-001 SHALL have parameter WIDTH, default 6, word width in bits.
REQ-002 SHALL have parameter DEST_BIT, default 4, index of the destination-select bit within the word.
REQ-003 SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  WIDTH  word from the upstream arbiter mux.
REQ-006 SHALL have port valid_in  input  1  data_in is valid this cycle.
REQ-007 SHALL have port D0_almost_full  input  1  destination FIFO 0 cannot accept a push.
REQ-008 SHALL have port D1_almost_full  input  1  destination FIFO 1 cannot accept a push.
REQ-009 SHALL have port D0_out  output  WIDTH  word to destination FIFO 0.
REQ-010 SHALL have port D0_push  output  1  D0_out is valid; one-cycle push pulse per word.
REQ-011 SHALL have port D1_out  output  WIDTH  word to destination FIFO 1.
REQ-012 SHALL have port D1_push  output  1  D1_out is valid; one-cycle push pulse per word.
REQ-013 SHALL have port pause  output  1  backpressure to the arbiter; no new word may be sent while high.
REQ-014 SHALL have port overflow  output  1  sticky error flag; a word was dropped.
REQ-015 SHALL have port count_D0  output  8  words delivered to D0.
REQ-016 SHALL have port count_D1  output  8  words delivered to D1.

Function
REQ-017 SHALL route each accepted word to destination x = data_in[DEST_BIT] (0 -> D0, 1 -> D1), word passed unmodified.
REQ-018 SHALL keep, per destination, a one-entry hold register (hold_x, hold_valid_x).
REQ-019 SHALL, per destination and per cycle, follow this priority: (a) hold_valid_x and !Dx_almost_full -> Dx_out <= hold_x, Dx_push <= 1, hold cleared; (b) hold_valid_x and Dx_almost_full -> Dx_push <= 0, hold kept; (c) hold empty, new word for x, !Dx_almost_full -> Dx_out <= word, Dx_push <= 1; (d) hold empty, new word for x, Dx_almost_full -> word into hold, Dx_push <= 0; (e) otherwise Dx_push <= 0.
REQ-020 SHALL, in case (a) with a new word for x in the same cycle, load the new word into the hold (hold_valid_x stays 1), preserving order.
REQ-021 SHALL, in case (b) with a new word for x, drop that word and set overflow to 1 until reset.
REQ-022 SHALL give 1-cycle latency data_in -> Dx_out/Dx_push when the path is clear.
REQ-023 SHALL hold Dx_out at its last value when Dx_push is 0.
REQ-024 SHALL drive pause = hold_valid_0 | hold_valid_1, taken directly from flops (no combinational path from inputs).
REQ-025 SHALL process both destinations independently; a word for D1 is accepted while D0 is stalled, subject to REQ-013 upstream.
REQ-026 SHALL increment count_x on every cycle Dx_push is registered 1, wrapping 255 -> 0.
REQ-027 SHALL ignore data_in when valid_in is 0.

Reset
REQ-028 SHALL, while reset is high, force D0_out, D1_out, hold registers, count_D0, count_D1 to 0 and D0_push, D1_push, hold_valid_0, hold_valid_1, pause, overflow to 0, independent of clk.
REQ-029 SHALL discard held words on reset mid-operation; no push SHALL occur on the first edge after reset deasserts unless valid_in is high for a clear path.

Verification
REQ-030 SHALL cover: valid_in=1, data_in=6'h15, both not almost full -> next cycle D1_out=6'h15, D1_push=1, count_D1=1, D0_push=0.
REQ-031 SHALL cover: D0_almost_full=1, send 6'h03 -> D0_push=0, pause=1; deassert almost_full -> next cycle D0_out=6'h03, D0_push=1, then pause=0.
REQ-032 SHALL cover: D0 hold full and D0_almost_full=1, send 6'h07 -> word dropped, overflow=1 and stays 1, count_D0 unchanged.
REQ-033 SHALL cover: D0 hold drains (case a) same cycle as new word 6'h0A for D0 -> held word pushed first, 6'h0A pushed next cycle in order.
REQ-034 SHALL cover: 256 pushes to D1 -> count_D1 wraps to 0.
REQ-035 SHALL cover: reset asserted mid-stall with hold_valid_0=1 -> all outputs 0 immediately, held word never pushed.

Source files
------------

// File: rtl/arbitro_demux_dest.sv
// arbitro_demux_dest: routes arbiter words to two destination FIFOs with one-entry hold and backpressure
module arbitro_demux_dest #(
  parameter int WIDTH = 6,
  parameter int DEST_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             D0_almost_full,
  input  logic             D1_almost_full,
  output logic [WIDTH-1:0] D0_out,
  output logic             D0_push,
  output logic [WIDTH-1:0] D1_out,
  output logic             D1_push,
  output logic             pause,
  output logic             overflow,
  output logic [7:0]       count_D0,
  output logic [7:0]       count_D1
);
  logic [1:0] af, new_w, push_n, drop, ld, hv, push_r;
  logic [WIDTH-1:0] hold [2];
  logic [WIDTH-1:0] dout [2];
  logic [7:0] cnt [2];
  assign af = {D1_almost_full, D0_almost_full};
  assign new_w = {valid_in & data_in[DEST_BIT], valid_in & ~data_in[DEST_BIT]};
  assign push_n = ~af & (hv | new_w);
  assign drop = hv & af & new_w;
  // a new word enters the hold either when the held one drains this cycle or when the path is blocked
  assign ld = new_w & (hv ^ af);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hv <= '0;
      push_r <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        hold[i] <= '0;
        dout[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      hv <= (hv & af) | ld;
      push_r <= push_n;
      if (|drop) overflow <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (push_n[i]) dout[i] <= hv[i] ? hold[i] : data_in;
        if (ld[i]) hold[i] <= data_in;
        cnt[i] <= cnt[i] + 8'(push_n[i]);
      end
    end
  end
  assign D0_out = dout[0];
  assign D1_out = dout[1];
  assign D0_push = push_r[0];
  assign D1_push = push_r[1];
  assign pause = |hv;
  assign count_D0 = cnt[0];
  assign count_D1 = cnt[1];
endmodule

// File: tb/tb_arbitro_demux_dest.sv
// tb_arbitro_demux_dest: directed self-checking bench for arbitro_demux_dest
module tb_arbitro_demux_dest;
  logic clk = 0, reset = 1, valid_in = 0, D0_almost_full = 0, D1_almost_full = 0;
  logic [5:0] data_in = '0;
  logic [5:0] D0_out, D1_out;
  logic D0_push, D1_push, pause, overflow;
  logic [7:0] count_D0, count_D1;
  int errors = 0, checks = 0;
  arbitro_demux_dest dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
    .D0_out(D0_out), .D0_push(D0_push), .D1_out(D1_out), .D1_push(D1_push),
    .pause(pause), .overflow(overflow), .count_D0(count_D0), .count_D1(count_D1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic v, input logic [5:0] d);
    valid_in = v;
    data_in = d;
    step();
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_d0out"}, D0_out, 0);
    chk({tag, "_d1out"}, D1_out, 0);
    chk({tag, "_d0push"}, D0_push, 0);
    chk({tag, "_d1push"}, D1_push, 0);
    chk({tag, "_pause"}, pause, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_cnt0"}, count_D0, 0);
    chk({tag, "_cnt1"}, count_D1, 0);
  endtask
  initial begin
    step();
    all_zero("rst");
    reset = 0;
    send(1, 6'h15);
    chk("r1_d1out", D1_out, 6'h15);
    chk("r1_d1push", D1_push, 1);
    chk("r1_cnt1", count_D1, 1);
    chk("r1_d0push", D0_push, 0);
    send(0, 6'h03);
    chk("idle_d1push", D1_push, 0);
    chk("idle_d0push", D0_push, 0);
    chk("idle_d1hold", D1_out, 6'h15);
    D0_almost_full = 1;
    send(1, 6'h03);
    chk("st_d0push", D0_push, 0);
    chk("st_pause", pause, 1);
    D0_almost_full = 0;
    send(0, 6'h00);
    chk("dr_d0out", D0_out, 6'h03);
    chk("dr_d0push", D0_push, 1);
    chk("dr_pause", pause, 0);
    chk("dr_cnt0", count_D0, 1);
    D0_almost_full = 1;
    send(1, 6'h04);
    chk("h4_pause", pause, 1);
    send(1, 6'h07);
    chk("ov_flag", overflow, 1);
    chk("ov_d0push", D0_push, 0);
    chk("ov_cnt0", count_D0, 1);
    send(0, 6'h00);
    chk("ov_sticky", overflow, 1);
    D0_almost_full = 0;
    send(1, 6'h0A);
    chk("ord1_d0out", D0_out, 6'h04);
    chk("ord1_push", D0_push, 1);
    chk("ord1_pause", pause, 1);
    send(0, 6'h00);
    chk("ord2_d0out", D0_out, 6'h0A);
    chk("ord2_push", D0_push, 1);
    chk("ord2_pause", pause, 0);
    chk("ord2_cnt0", count_D0, 3);
    send(0, 6'h00);
    chk("ord3_push", D0_push, 0);
    chk("ord3_d0out", D0_out, 6'h0A);
    D0_almost_full = 1;
    send(1, 6'h02);
    send(1, 6'h11);
    chk("ind_d1out", D1_out, 6'h11);
    chk("ind_d1push", D1_push, 1);
    chk("ind_d0push", D0_push, 0);
    chk("ind_cnt1", count_D1, 2);
    chk("ind_pause", pause, 1);
    valid_in = 0;
    #2 reset = 1;
    #1;
    all_zero("arst");
    @(negedge clk);
    reset = 0;
    D0_almost_full = 0;
    send(0, 6'h00);
    chk("post_d0push", D0_push, 0);
    chk("post_pause", pause, 0);
    chk("post_cnt0", count_D0, 0);
    for (int i = 0; i < 255; i++) send(1, 6'h10);
    chk("wr_cnt255", count_D1, 255);
    chk("wr_push", D1_push, 1);
    send(1, 6'h10);
    chk("wr_cnt0", count_D1, 0);
    chk("wr_cnt0_d0", count_D0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
